// File: rtl/arm_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for the ARM32 decode stage.
// The decode stage is the slave; the surrounding pipeline (or a bench) is the master.
interface arm_decode_stage_if #(
    parameter int ARCH = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [ARCH-1:0] in_ins;
    logic [ARCH-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [ARCH-1:0] out_pc;
    logic [3:0]      out_cond;
    logic [2:0]      out_class;
    logic [3:0]      out_opcode;
    logic            out_s;
    logic            out_load;
    logic            out_up;
    logic            out_link;
    logic [3:0]      out_rn;
    logic [3:0]      out_rd;
    logic [3:0]      out_rm;
    logic [ARCH-1:0] out_imm;
    logic [ARCH-1:0] out_target;

    modport master (
        output in_valid, in_ins, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_cond, out_class, out_opcode,
               out_s, out_load, out_up, out_link, out_rn, out_rd, out_rm,
               out_imm, out_target
    );

    modport slave (
        input  in_valid, in_ins, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_cond, out_class, out_opcode,
               out_s, out_load, out_up, out_link, out_rn, out_rd, out_rm,
               out_imm, out_target
    );
endinterface

// File: rtl/arm_decode_stage.sv
// ARM32 decode stage: splits the fetched word into fields, immediates and branch target,
// and hands it to execute through an output register backed by one skid register.
module arm_decode_stage #(
    parameter int ARCH      = 32,
    parameter int PC_OFFSET = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    arm_decode_stage_if.slave   bus,
    output logic [15:0]         undef_count
);

    typedef enum logic [2:0] {
        CLS_DP_REG = 3'd0,
        CLS_DP_IMM = 3'd1,
        CLS_LDST   = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_UNDEF  = 3'd4
    } ins_class_e;

    typedef struct packed {
        logic [ARCH-1:0] pc;
        logic [3:0]      cond;
        ins_class_e      cls;
        logic [3:0]      opcode;
        logic            s;
        logic            load;
        logic            up;
        logic            link;
        logic [3:0]      rn;
        logic [3:0]      rd;
        logic [3:0]      rm;
        logic [ARCH-1:0] imm;
        logic [ARCH-1:0] target;
    } dec_t;

    // Occupancy of the two-entry buffer: HALF = output register only, FULL = skid too.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_HALF  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e            state;
    occ_e            state_next;
    dec_t            dec;
    dec_t            out_q;
    dec_t            skid_q;
    logic [ARCH-1:0] ins;
    logic [2*ARCH-1:0] rot_dbl;
    logic [ARCH-1:0] branch_off;
    logic            accept;
    logic            consume;
    logic            load_out;
    logic            load_skid;
    logic            move_skid;
    logic [15:0]     undef_cnt_q;

    assign ins        = bus.in_ins;
    assign rot_dbl    = {{(ARCH-8){1'b0}}, ins[7:0], {(ARCH-8){1'b0}}, ins[7:0]}
                        >> {ins[11:8], 1'b0};
    assign branch_off = {{(ARCH-26){ins[23]}}, ins[23:0], 2'b00};

    always_comb begin
        dec        = '0;
        dec.pc     = bus.in_pc;
        dec.cond   = ins[31:28];
        dec.rn     = ins[19:16];
        dec.rd     = ins[15:12];
        dec.rm     = ins[3:0];
        dec.cls    = CLS_UNDEF;
        if (ins[31:28] != 4'hF) begin
            case (ins[27:26])
                2'b00:   dec.cls = ins[25] ? CLS_DP_IMM : CLS_DP_REG;
                2'b01:   dec.cls = ins[25] ? CLS_UNDEF  : CLS_LDST;
                2'b10:   dec.cls = ins[25] ? CLS_BRANCH : CLS_UNDEF;
                default: dec.cls = CLS_UNDEF;
            endcase
        end
        case (dec.cls)
            CLS_DP_REG: begin
                dec.opcode = ins[24:21];
                dec.s      = ins[20];
            end
            CLS_DP_IMM: begin
                dec.opcode = ins[24:21];
                dec.s      = ins[20];
                dec.imm    = rot_dbl[ARCH-1:0];
            end
            CLS_LDST: begin
                dec.load = ins[20];
                dec.up   = ins[23];
                dec.imm  = {{(ARCH-12){1'b0}}, ins[11:0]};
            end
            CLS_BRANCH: begin
                dec.link   = ins[24];
                dec.target = bus.in_pc + ARCH'(PC_OFFSET) + branch_off;
            end
            default: ;
        endcase
    end

    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Flush wins over any transfer, so it forces the buffer empty regardless of handshakes.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: if (accept) state_next = OCC_HALF;
                OCC_HALF: begin
                    if (accept && !bus.out_ready)      state_next = OCC_FULL;
                    else if (!accept && bus.out_ready) state_next = OCC_EMPTY;
                end
                OCC_FULL:  if (bus.out_ready) state_next = OCC_HALF;
                default:   state_next = OCC_EMPTY;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state != OCC_FULL);
        bus.out_valid = (state != OCC_EMPTY);
        load_out      = 1'b0;
        load_skid     = 1'b0;
        move_skid     = 1'b0;
        if (!flush) begin
            load_out  = accept && (state == OCC_EMPTY || bus.out_ready);
            load_skid = accept && (state == OCC_HALF) && !bus.out_ready;
            move_skid = (state == OCC_FULL) && bus.out_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (move_skid)
                out_q <= skid_q;
            else if (load_out)
                out_q <= dec;
            if (load_skid)
                skid_q <= dec;
        end
    end

    // Only instructions actually handed to execute are counted; flushed ones never are.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            undef_cnt_q <= 16'd0;
        end else if (!flush && consume && out_q.cls == CLS_UNDEF && undef_cnt_q != 16'hFFFF) begin
            undef_cnt_q <= undef_cnt_q + 16'd1;
        end
    end

    assign undef_count    = undef_cnt_q;
    assign bus.out_pc     = out_q.pc;
    assign bus.out_cond   = out_q.cond;
    assign bus.out_class  = out_q.cls;
    assign bus.out_opcode = out_q.opcode;
    assign bus.out_s      = out_q.s;
    assign bus.out_load   = out_q.load;
    assign bus.out_up     = out_q.up;
    assign bus.out_link   = out_q.link;
    assign bus.out_rn     = out_q.rn;
    assign bus.out_rd     = out_q.rd;
    assign bus.out_rm     = out_q.rm;
    assign bus.out_imm    = out_q.imm;
    assign bus.out_target = out_q.target;

endmodule

// File: tb/tb_arm_decode_stage.sv
// Directed bench for arm_decode_stage: field decode, immediates, branch targets,
// skid-buffer ordering, flush and the saturating UNDEF counter.
module tb_arm_decode_stage;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic [15:0] undef_count;
    int          checks;
    int          errors;

    arm_decode_stage_if #(.ARCH(32)) bus ();

    arm_decode_stage #(.ARCH(32), .PC_OFFSET(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .bus         (bus),
        .undef_count (undef_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic valid, input logic [31:0] ins,
                                 input logic [31:0] pc, input logic oready,
                                 input logic fl);
        bus.in_valid  = valid;
        bus.in_ins    = ins;
        bus.in_pc     = pc;
        bus.out_ready = oready;
        flush         = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        tick();
        tick();
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_undef", 32'(undef_count), 32'd0);
        checkOutput("reset_imm", bus.out_imm, 32'd0);
        checkOutput("reset_pc", bus.out_pc, 32'd0);
        reset_n = 1'b1;

        // MOV r1,#5
        applyStimulus(1'b1, 32'hE3A01005, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("mov_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("mov_class", 32'(bus.out_class), 32'd1);
        checkOutput("mov_opcode", 32'(bus.out_opcode), 32'hD);
        checkOutput("mov_rd", 32'(bus.out_rd), 32'd1);
        checkOutput("mov_imm", bus.out_imm, 32'd5);
        checkOutput("mov_cond", 32'(bus.out_cond), 32'hE);
        checkOutput("mov_s", 32'(bus.out_s), 32'd0);

        applyStimulus(1'b1, 32'hE3A004FF, 32'h4, 1'b1, 1'b0);
        tick();
        checkOutput("rot_imm", bus.out_imm, 32'hFF000000);
        checkOutput("rot_pc", bus.out_pc, 32'h4);
        checkOutput("rot_valid", 32'(bus.out_valid), 32'd1);

        applyStimulus(1'b1, 32'hEBFFFFFE, 32'h100, 1'b1, 1'b0);
        tick();
        checkOutput("bl_class", 32'(bus.out_class), 32'd3);
        checkOutput("bl_link", 32'(bus.out_link), 32'd1);
        checkOutput("bl_target", bus.out_target, 32'h100);
        checkOutput("bl_opcode", 32'(bus.out_opcode), 32'd0);
        checkOutput("bl_imm", bus.out_imm, 32'd0);

        applyStimulus(1'b1, 32'hEB000000, 32'hFFFFFFF8, 1'b1, 1'b0);
        tick();
        checkOutput("wrap_target", bus.out_target, 32'h0);

        // LDR r2,[r1,#4]
        applyStimulus(1'b1, 32'hE5912004, 32'h10, 1'b1, 1'b0);
        tick();
        checkOutput("ldr_class", 32'(bus.out_class), 32'd2);
        checkOutput("ldr_load", 32'(bus.out_load), 32'd1);
        checkOutput("ldr_up", 32'(bus.out_up), 32'd1);
        checkOutput("ldr_rn", 32'(bus.out_rn), 32'd1);
        checkOutput("ldr_rd", 32'(bus.out_rd), 32'd2);
        checkOutput("ldr_imm", bus.out_imm, 32'd4);
        checkOutput("ldr_target", bus.out_target, 32'd0);
        checkOutput("ldr_s", 32'(bus.out_s), 32'd0);

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("drain_valid", 32'(bus.out_valid), 32'd0);

        // Stream A,B,C with the consumer stalled for two cycles
        applyStimulus(1'b1, 32'hE3A00001, 32'h200, 1'b0, 1'b0);
        tick();
        checkOutput("a_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("a_in_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b1, 32'hE3A00002, 32'h204, 1'b0, 1'b0);
        tick();
        checkOutput("a_hold1_imm", bus.out_imm, 32'd1);
        checkOutput("skid_in_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(1'b1, 32'hE3A00003, 32'h208, 1'b0, 1'b0);
        tick();
        checkOutput("a_hold2_imm", bus.out_imm, 32'd1);
        checkOutput("a_hold2_pc", bus.out_pc, 32'h200);
        checkOutput("a_hold2_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("c_blocked_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(1'b1, 32'hE3A00003, 32'h208, 1'b1, 1'b0);
        tick();
        checkOutput("b_imm", bus.out_imm, 32'd2);
        checkOutput("b_pc", bus.out_pc, 32'h204);
        checkOutput("b_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        checkOutput("c_imm", bus.out_imm, 32'd3);
        checkOutput("c_pc", bus.out_pc, 32'h208);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("abc_drained", 32'(bus.out_valid), 32'd0);

        // Fill both entries, then flush alongside a new instruction
        applyStimulus(1'b1, 32'hE3A00004, 32'h300, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hE3A00005, 32'h304, 1'b0, 1'b0);
        tick();
        checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(1'b1, 32'hE3A00007, 32'h308, 1'b0, 1'b1);
        tick();
        checkOutput("flush_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b1, 32'hE3A00008, 32'h30C, 1'b1, 1'b1);
        tick();
        checkOutput("flush_accept_dropped", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("flush_nothing_later", 32'(bus.out_valid), 32'd0);

        // UNDEF encodings and their delivery count
        applyStimulus(1'b1, 32'hF0000000, 32'h400, 1'b1, 1'b0);
        tick();
        checkOutput("undef_f_class", 32'(bus.out_class), 32'd4);
        checkOutput("undef_f_cond", 32'(bus.out_cond), 32'hF);
        checkOutput("undef_cnt0", 32'(undef_count), 32'd0);
        applyStimulus(1'b1, 32'hE6000010, 32'h404, 1'b1, 1'b0);
        tick();
        checkOutput("undef_reg_class", 32'(bus.out_class), 32'd4);
        checkOutput("undef_reg_opcode", 32'(bus.out_opcode), 32'd0);
        checkOutput("undef_cnt1", 32'(undef_count), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("undef_cnt2", 32'(undef_count), 32'd2);

        // A flushed UNDEF is never counted
        applyStimulus(1'b1, 32'hF0000000, 32'h408, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        checkOutput("undef_flush_cnt", 32'(undef_count), 32'd2);
        flush = 1'b0;

        // Saturation: preload the counter just below the ceiling
        force dut.undef_cnt_q = 16'hFFFE;
        #1;
        release dut.undef_cnt_q;
        applyStimulus(1'b1, 32'hF0000000, 32'h500, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("undef_sat_reach", 32'(undef_count), 32'hFFFF);
        applyStimulus(1'b1, 32'hF0000000, 32'h504, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("undef_sat_hold", 32'(undef_count), 32'hFFFF);

        // Reset while both entries are occupied
        applyStimulus(1'b1, 32'hE3A00009, 32'h600, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hE3A0000A, 32'h604, 1'b0, 1'b0);
        tick();
        reset_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("midreset_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midreset_undef", 32'(undef_count), 32'd0);
        reset_n = 1'b1;
        tick();
        checkOutput("midreset_no_skid", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
